pc_alu_branch_unit: RTL and testbench

//  Core datapath slice of the 5-stage RV32 pipeline: program counter (IF), 32-bit integer ALU
//  and branch decider (EX). PC steps sequentially, holds on a load-use stall, redirects on a

---
 rtl/rv_core_pkg.sv | 26 ++
 rtl/alu_core.sv | 47 ++++
 rtl/pc_alu_branch_unit.sv | 71 +++++++
 tb/tb_pc_alu_branch_unit.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv_core_pkg.sv
// Shared types and constants for the RV32 core datapath slice.
package rv_core_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [2:0] {
        ALU_ADD    = 3'b000,
        ALU_SUB    = 3'b001,
        ALU_AND    = 3'b010,
        ALU_OR     = 3'b011,
        ALU_XOR    = 3'b100,
        ALU_PASS_B = 3'b101
    } alu_op_e;

    // RISC-V funct3 encoding; 3'b011 is also a non-branch slot.
    typedef enum logic [2:0] {
        BR_BEQ  = 3'b000,
        BR_BNE  = 3'b001,
        BR_NONE = 3'b010,
        BR_BLT  = 3'b100,
        BR_BGE  = 3'b101,
        BR_BLTU = 3'b110,
        BR_BGEU = 3'b111
    } branch_type_e;

endpackage

// File: rtl/alu_core.sv
// 32-bit integer ALU with zero/neg/carry/overflow flags, purely combinational.
module alu_core
    import rv_core_pkg::*;
(
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [2:0]      op,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            neg,
    output logic            c_out,
    output logic            over
);

    logic [XLEN:0] sum;

    // Operation select; carry/overflow only meaningful for ADD/SUB.
    always_comb begin
        sum    = '0;
        result = '0;
        c_out  = 1'b0;
        over   = 1'b0;
        case (alu_op_e'(op))
            ALU_ADD: begin
                sum    = {1'b0, a} + {1'b0, b};
                result = sum[XLEN-1:0];
                c_out  = sum[XLEN];
                over   = (a[XLEN-1] == b[XLEN-1]) && (result[XLEN-1] != a[XLEN-1]);
            end
            ALU_SUB: begin
                sum    = {1'b0, a} + {1'b0, ~b} + (XLEN+1)'(1);
                result = sum[XLEN-1:0];
                c_out  = sum[XLEN];
                over   = (a[XLEN-1] != b[XLEN-1]) && (result[XLEN-1] != a[XLEN-1]);
            end
            ALU_AND:    result = a & b;
            ALU_OR:     result = a | b;
            ALU_XOR:    result = a ^ b;
            ALU_PASS_B: result = b;
            default:    result = '0;
        endcase
    end

    assign zero = (result == '0);
    assign neg  = result[XLEN-1];

endmodule

// File: rtl/pc_alu_branch_unit.sv
// IF-stage program counter plus EX-stage ALU and branch decider.
module pc_alu_branch_unit
    import rv_core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pc_src,
    input  logic        stall,
    input  logic [31:0] jump_addr,
    output logic [31:0] i_addr,
    output logic        i_valid,
    input  logic [31:0] alu_a,
    input  logic [31:0] alu_b,
    input  logic [2:0]  alu_op,
    output logic [31:0] result,
    output logic        zero,
    output logic        neg,
    output logic        c_out,
    output logic        over,
    input  logic [2:0]  branch_type,
    output logic        branch_taken
);

    // Low address bits are forced to zero on redirect.
    logic unused_jump_lsbs;
    assign unused_jump_lsbs = ^jump_addr[1:0];

    // PC register: redirect beats stall; stalled slot is flagged as a replay.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            i_addr  <= RESET_PC;
            i_valid <= 1'b0;
        end else begin
            if (pc_src) begin
                i_addr <= {jump_addr[31:2], 2'b00};
            end else if (!stall) begin
                i_addr <= i_addr + 32'(PC_STEP);
            end
            i_valid <= pc_src | ~stall;
        end
    end

    alu_core u_alu_core (
        .a      (alu_a),
        .b      (alu_b),
        .op     (alu_op),
        .result (result),
        .zero   (zero),
        .neg    (neg),
        .c_out  (c_out),
        .over   (over)
    );

    // Branch condition from the ALU flags (caller drives SUB for compares).
    always_comb begin
        branch_taken = 1'b0;
        case (branch_type_e'(branch_type))
            BR_BEQ:  branch_taken = zero;
            BR_BNE:  branch_taken = ~zero;
            BR_BLT:  branch_taken = neg ^ over;
            BR_BGE:  branch_taken = ~(neg ^ over);
            BR_BLTU: branch_taken = ~c_out;
            BR_BGEU: branch_taken = c_out;
            default: branch_taken = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_pc_alu_branch_unit.sv
// Self-checking bench for pc_alu_branch_unit against an arithmetic reference model.
module tb_pc_alu_branch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        pc_src;
    logic        stall;
    logic [31:0] jump_addr;
    logic [31:0] i_addr;
    logic        i_valid;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_op;
    logic [31:0] result;
    logic        zero;
    logic        neg;
    logic        c_out;
    logic        over;
    logic [2:0]  branch_type;
    logic        branch_taken;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_pc;
    logic        exp_v;

    always #5 clk = ~clk;

    pc_alu_branch_unit dut (
        .clk          (clk),
        .reset        (reset),
        .pc_src       (pc_src),
        .stall        (stall),
        .jump_addr    (jump_addr),
        .i_addr       (i_addr),
        .i_valid      (i_valid),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_op       (alu_op),
        .result       (result),
        .zero         (zero),
        .neg          (neg),
        .c_out        (c_out),
        .over         (over),
        .branch_type  (branch_type),
        .branch_taken (branch_taken)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference ALU from plain integer arithmetic.
    task automatic alu_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] r, output logic c, output logic o);
        longint sa, sb, ss;
        logic [63:0] u;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r = 32'h0; c = 1'b0; o = 1'b0;
        case (op)
            3'd0: begin
                u  = {32'h0, a} + {32'h0, b};
                r  = u[31:0];
                c  = u[32];
                ss = sa + sb;
                o  = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
            end
            3'd1: begin
                r  = a - b;
                c  = (a >= b);
                ss = sa - sb;
                o  = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = b;
            default: r = 32'h0;
        endcase
    endtask

    function automatic logic br_ref(input logic [2:0] bt, input logic [31:0] a, input logic [31:0] b);
        case (bt)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd4:    return $signed(a) < $signed(b);
            3'd5:    return $signed(a) >= $signed(b);
            3'd6:    return a < b;
            3'd7:    return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    // One clock edge: advance the PC model from current inputs, then compare.
    task automatic pc_edge(input string tag);
        @(posedge clk);
        if (pc_src)      exp_pc = jump_addr & 32'hFFFF_FFFC;
        else if (!stall) exp_pc = exp_pc + 32'd4;
        exp_v = pc_src | ~stall;
        #1;
        chk({tag, "_addr"}, i_addr, exp_pc);
        chk({tag, "_valid"}, 32'(i_valid), 32'(exp_v));
    endtask

    // Apply ALU inputs and compare result, flags and branch decision.
    task automatic alu_check(input string tag, input logic [2:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [2:0] bt);
        logic [31:0] r;
        logic c, o;
        alu_op = op; alu_a = a; alu_b = b; branch_type = bt;
        #1;
        alu_ref(op, a, b, r, c, o);
        chk({tag, "_result"}, result, r);
        chk({tag, "_zero"}, 32'(zero), 32'(r == 32'h0));
        chk({tag, "_neg"}, 32'(neg), 32'(r[31]));
        chk({tag, "_cout"}, 32'(c_out), 32'(c));
        chk({tag, "_over"}, 32'(over), 32'(o));
        if (op == 3'd1) chk({tag, "_taken"}, 32'(branch_taken), 32'(br_ref(bt, a, b)));
        else if (bt == 3'd2 || bt == 3'd3) chk({tag, "_none"}, 32'(branch_taken), 32'(0));
    endtask

    task automatic br_check(input string tag, input logic [2:0] bt, input logic expv);
        branch_type = bt;
        #1;
        chk(tag, 32'(branch_taken), 32'(expv));
    endtask

    initial begin
        reset = 1'b1; pc_src = 1'b0; stall = 1'b0; jump_addr = 32'h0;
        alu_a = 32'h0; alu_b = 32'h0; alu_op = 3'd0; branch_type = 3'd2;
        #12;
        chk("rst_addr", i_addr, 32'h0);
        chk("rst_valid", 32'(i_valid), 32'(0));
        reset = 1'b0;
        exp_pc = 32'h0; exp_v = 1'b0;

        // Sequential fetch 0 -> 4 -> 8 -> 12
        pc_edge("seq1");
        pc_edge("seq2");
        chk("seq_at8", i_addr, 32'h8);
        pc_edge("seq3");
        chk("seq_at12", i_addr, 32'hC);

        // Two-cycle stall then release
        stall = 1'b1;
        pc_edge("stall1");
        pc_edge("stall2");
        chk("stall_hold", i_addr, 32'hC);
        stall = 1'b0;
        pc_edge("release");
        chk("release_addr", i_addr, 32'h10);

        // Redirect beats stall, low bits cleared
        stall = 1'b1; pc_src = 1'b1; jump_addr = 32'h103;
        pc_edge("redir");
        chk("redir_addr", i_addr, 32'h100);
        chk("redir_valid", 32'(i_valid), 32'(1));
        stall = 1'b0; pc_src = 1'b0;

        // Randomized PC control
        for (int i = 0; i < 40; i++) begin
            stall     = ($urandom_range(0, 3) == 0);
            pc_src    = ($urandom_range(0, 4) == 0);
            jump_addr = $urandom;
            pc_edge("pc_rand");
        end

        // Wrap-around at the top of the address space
        stall = 1'b0; pc_src = 1'b1; jump_addr = 32'hFFFF_FFFF;
        pc_edge("wrap_setup");
        chk("wrap_top", i_addr, 32'hFFFF_FFFC);
        pc_src = 1'b0;
        pc_edge("wrap");
        chk("wrap_zero", i_addr, 32'h0);
        pc_edge("post_wrap");

        // Asynchronous reset mid-run, release mid-cycle
        #3 reset = 1'b1;
        #1;
        chk("async_rst_addr", i_addr, 32'h0);
        chk("async_rst_valid", 32'(i_valid), 32'(0));
        @(posedge clk); #1;
        chk("rst_held_addr", i_addr, 32'h0);
        #3 reset = 1'b0;
        exp_pc = 32'h0; exp_v = 1'b0;
        pc_edge("after_rst");
        chk("after_rst_addr", i_addr, 32'h4);

        // Directed ALU: SUB 5-5
        alu_check("sub_eq", 3'd1, 32'd5, 32'd5, 3'd0);
        chk("sub_eq_res0", result, 32'h0);
        chk("sub_eq_c", 32'(c_out), 32'(1));
        br_check("sub_eq_beq", 3'd0, 1'b1);
        br_check("sub_eq_bne", 3'd1, 1'b0);
        br_check("sub_eq_bltu", 3'd6, 1'b0);

        // Directed ALU: SUB min-int minus 1 overflows
        alu_check("sub_ovf", 3'd1, 32'h8000_0000, 32'd1, 3'd4);
        chk("sub_ovf_res", result, 32'h7FFF_FFFF);
        chk("sub_ovf_over", 32'(over), 32'(1));
        chk("sub_ovf_neg", 32'(neg), 32'(0));
        br_check("sub_ovf_blt", 3'd4, 1'b1);
        br_check("sub_ovf_bgeu", 3'd7, 1'b1);

        // Directed ALU: ADD carry without overflow
        alu_check("add_wrap", 3'd0, 32'hFFFF_FFFF, 32'd1, 3'd2);
        chk("add_wrap_res", result, 32'h0);
        chk("add_wrap_c", 32'(c_out), 32'(1));
        chk("add_wrap_over", 32'(over), 32'(0));

        // Reserved opcodes and non-branch types
        alu_check("op6", 3'd6, 32'h1234_5678, 32'h9ABC_DEF0, 3'd3);
        alu_check("op7", 3'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd2);

        // Randomized ALU and branches
        for (int i = 0; i < 300; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? ra : $urandom;
            if ($urandom_range(0, 5) == 0) ra = {ra[31], 31'h0};
            alu_check("alu_rand", 3'($urandom_range(0, 7)), ra, rb, 3'($urandom_range(0, 7)));
            alu_check("br_rand", 3'd1, ra, rb, 3'($urandom_range(0, 7)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
